bcd_score_display: RTL and testbench

Parametrised decimal score counter with a time-multiplexed, active-low seven-segment driver. It counts rising edges of the asynchronous `add_cube` event line in packed BCD across `DIGITS` decades. Overflow is configurable to wrap or saturate, and leading-zero blanking is optional. The block sits between game logic and the board's common-anode digit bank, replacing a fixed two-digit, per-digit-decoder score display.

---
 rtl/bcd_score_display.sv | 145 ++++++++++++++
 tb/tb_bcd_score_display.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_display.sv
// Decimal score counter fed by an asynchronous event line, with a registered,
// time-multiplexed active-low seven-segment driver for a common-anode digit bank.
module bcd_score_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter bit SATURATE = 1'b0,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                add_cube,
    input  logic                clear,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic                overflow,
    output logic [6:0]          seg_out,
    output logic [DIGITS-1:0]   sel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [2:0]          sync_q;
    logic                inc;
    logic [4*DIGITS-1:0] score_q, score_d, inc_score;
    logic                carry_out;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic                higher_zero;
    logic                carry;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Flops preset to 1 so a line already high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], add_cube};
        end
    end

    assign inc = sync_q[1] & ~sync_q[2];

    always_comb begin
        inc_score = score_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    inc_score[4*i +: 4] = 4'd0;
                end else begin
                    inc_score[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        carry_out = carry;
    end

    // Clear has priority and swallows a coincident increment, overflow included.
    always_comb begin
        score_d = score_q;
        ovf_d   = 1'b0;
        if (clear) begin
            score_d = '0;
        end else if (inc) begin
            if (carry_out) begin
                ovf_d   = 1'b1;
                score_d = SATURATE ? score_q : '0;
            end else begin
                score_d = inc_score;
            end
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        higher_zero = 1'b1;
        cur_digit   = 4'd0;
        cur_blank   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (score_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_digit = score_q[4*i +: 4];
                cur_blank = BLANK_LZ && (i != 0) && higher_zero;
            end
        end
        seg_d = cur_blank ? 7'h7F : decode(cur_digit);
        sel_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            score_q <= '0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            sel_q   <= '1;
        end else begin
            score_q <= score_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign score_bcd = score_q;
    assign overflow  = ovf_q;
    assign seg_out   = seg_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Self-checking bench: a wrapping and a saturating instance share one stimulus
// stream and are compared against an integer score model.
module tb_bcd_score_display;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        add_cube = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] scoreW, scoreS;
    logic        ovfW, ovfS;
    logic [6:0]  segW, segS;
    logic [3:0]  selW, selS;

    int testsRun = 0;
    int testsFailed = 0;
    int modelW = 0, modelS = 0;
    int ovfExpW = 0, ovfExpS = 0;
    int ovfSeenW = 0, ovfSeenS = 0;
    logic prevOvfW = 1'b0, prevOvfS = 1'b0;

    typedef struct {
        bit              doClear;
        int              pulses;
        logic [15:0]     expScore;
        logic [3:0][6:0] expSeg;
    } vec_t;

    vec_t vecs[8];

    bcd_score_display #(.DIGITS(4), .SCAN_DIV(3), .SATURATE(1'b0), .BLANK_LZ(1'b1)) dutWrap (
        .clk(clk), .RSTn(RSTn), .add_cube(add_cube), .clear(clear),
        .score_bcd(scoreW), .overflow(ovfW), .seg_out(segW), .sel(selW)
    );

    bcd_score_display #(.DIGITS(4), .SCAN_DIV(3), .SATURATE(1'b1), .BLANK_LZ(1'b1)) dutSat (
        .clk(clk), .RSTn(RSTn), .add_cube(add_cube), .clear(clear),
        .score_bcd(scoreS), .overflow(ovfS), .seg_out(segS), .sel(selS)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void modelAdd();
        if (modelW == 9999) begin
            modelW = 0;
            ovfExpW++;
        end else begin
            modelW++;
        end
        if (modelS == 9999) begin
            ovfExpS++;
        end else begin
            modelS++;
        end
    endfunction

    task automatic applyStimulus(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            add_cube = 1'b1;
            step(hi);
            add_cube = 1'b0;
            step(lo);
            modelAdd();
        end
    endtask

    task automatic clearScore();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        modelW = 0;
        modelS = 0;
    endtask

    task automatic checkFrame(input int vi);
        logic [3:0] expSel;
        int bound;
        for (int k = 0; k < 4; k++) begin
            expSel = ~(4'b0001 << k);
            bound = 0;
            while (selW !== expSel && bound < 20) begin
                step(1);
                bound++;
            end
            checkOutput("frameSel", {28'd0, selW}, {28'd0, expSel});
            checkOutput("frameSegWrap", {25'd0, segW}, {25'd0, vecs[vi].expSeg[k]});
            checkOutput("frameSegSat", {25'd0, segS}, {25'd0, vecs[vi].expSeg[k]});
        end
    endtask

    task automatic checkScanPeriod();
        logic [3:0] cur, expSel;
        int bound, cnt;
        bound = 0;
        while (selW === 4'b1110 && bound < 20) begin step(1); bound++; end
        while (selW !== 4'b1110 && bound < 40) begin step(1); bound++; end
        for (int k = 0; k < 4; k++) begin
            expSel = ~(4'b0001 << k);
            cur = selW;
            checkOutput("scanOrder", {28'd0, cur}, {28'd0, expSel});
            cnt = 0;
            while (selW === cur && cnt < 20) begin step(1); cnt++; end
            checkOutput("scanPeriod", cnt, 3);
        end
    endtask

    // Overflow must be a single-cycle pulse coinciding with the wrapped or held score.
    always begin
        @(posedge clk);
        #1;
        if (RSTn) begin
            if (ovfW === 1'b1) begin
                ovfSeenW++;
                checkOutput("ovfWrapScore", {16'd0, scoreW}, 32'h0000);
                checkOutput("ovfWrapWidth", {31'd0, prevOvfW}, 32'd0);
            end
            if (ovfS === 1'b1) begin
                ovfSeenS++;
                checkOutput("ovfSatScore", {16'd0, scoreS}, 32'h9999);
                checkOutput("ovfSatWidth", {31'd0, prevOvfS}, 32'd0);
            end
        end
        prevOvfW = ovfW;
        prevOvfS = ovfS;
    end

    initial begin
        vecs[0] = '{doClear: 1'b1, pulses: 0,    expScore: 16'h0000, expSeg: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[1] = '{doClear: 1'b0, pulses: 7,    expScore: 16'h0007, expSeg: {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        vecs[2] = '{doClear: 1'b1, pulses: 105,  expScore: 16'h0105, expSeg: {7'h7F, 7'h79, 7'h40, 7'h12}};
        vecs[3] = '{doClear: 1'b1, pulses: 1234, expScore: 16'h1234, expSeg: {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[4] = '{doClear: 1'b0, pulses: 6,    expScore: 16'h1240, expSeg: {7'h79, 7'h24, 7'h19, 7'h40}};
        vecs[5] = '{doClear: 1'b1, pulses: 86,   expScore: 16'h0086, expSeg: {7'h7F, 7'h7F, 7'h00, 7'h02}};
        vecs[6] = '{doClear: 1'b1, pulses: 9,    expScore: 16'h0009, expSeg: {7'h7F, 7'h7F, 7'h7F, 7'h10}};
        vecs[7] = '{doClear: 1'b0, pulses: 1,    expScore: 16'h0010, expSeg: {7'h7F, 7'h7F, 7'h79, 7'h40}};

        // Reset with the event line held high throughout and after release.
        add_cube = 1'b1;
        step(3);
        checkOutput("rstScore", {16'd0, scoreW}, 32'd0);
        checkOutput("rstOvf", {31'd0, ovfW}, 32'd0);
        checkOutput("rstSeg", {25'd0, segW}, 32'h7F);
        checkOutput("rstSel", {28'd0, selW}, 32'hF);
        @(negedge clk);
        RSTn = 1'b1;
        step(1);
        checkOutput("postRstSel1", {28'd0, selW}, 32'hE);
        checkOutput("postRstSeg1", {25'd0, segW}, 32'h40);
        step(2);
        checkOutput("postRstSel3", {28'd0, selW}, 32'hE);
        step(1);
        checkOutput("postRstSel4", {28'd0, selW}, 32'hD);
        step(6);
        checkOutput("heldHighScoreW", {16'd0, scoreW}, 32'd0);
        checkOutput("heldHighScoreS", {16'd0, scoreS}, 32'd0);
        add_cube = 1'b0;
        step(4);
        checkOutput("fallNoCount", {16'd0, scoreW}, 32'd0);

        checkScanPeriod();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].doClear) clearScore();
            applyStimulus(vecs[v].pulses, 2, 2);
            checkOutput("tableScoreWrap", {16'd0, scoreW}, {16'd0, vecs[v].expScore});
            checkOutput("tableScoreSat", {16'd0, scoreS}, {16'd0, vecs[v].expScore});
            checkFrame(v);
        end

        // Randomised events and clears against the integer model.
        clearScore();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                clearScore();
            end else begin
                applyStimulus(1, $urandom_range(2, 4), $urandom_range(2, 4));
            end
            checkOutput("randScoreWrap", {16'd0, scoreW}, {16'd0, toBcd(modelW)});
            checkOutput("randScoreSat", {16'd0, scoreS}, {16'd0, toBcd(modelS)});
        end

        // Clear arriving in the same cycle as the increment pulse.
        clearScore();
        applyStimulus(42, 2, 2);
        checkOutput("preCollide", {16'd0, scoreW}, 32'h0042);
        add_cube = 1'b1;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checkOutput("collideScore", {16'd0, scoreW}, 32'h0000);
        checkOutput("collideOvf", {31'd0, ovfW}, 32'd0);
        step(1);
        add_cube = 1'b0;
        step(3);
        modelW = 0;
        modelS = 0;
        checkOutput("collideAfter", {16'd0, scoreW}, 32'h0000);
        applyStimulus(1, 2, 2);
        checkOutput("collideNext", {16'd0, scoreW}, 32'h0001);

        // Reset while an edge is still in the synchronizer.
        add_cube = 1'b1;
        step(1);
        RSTn = 1'b0;
        #2;
        checkOutput("midRstScore", {16'd0, scoreW}, 32'd0);
        checkOutput("midRstSel", {28'd0, selW}, 32'hF);
        @(negedge clk);
        RSTn = 1'b1;
        step(4);
        add_cube = 1'b0;
        step(3);
        modelW = 0;
        modelS = 0;
        checkOutput("midRstLost", {16'd0, scoreW}, 32'd0);

        // Climb to all-nines, then overflow once (wrap) and three times (saturate).
        applyStimulus(9999, 2, 2);
        checkOutput("nineWrap", {16'd0, scoreW}, 32'h9999);
        checkOutput("nineSat", {16'd0, scoreS}, 32'h9999);
        add_cube = 1'b1;
        step(2);
        checkOutput("ovfE1", {31'd0, ovfW}, 32'd0);
        checkOutput("ovfE1Score", {16'd0, scoreW}, 32'h9999);
        step(1);
        checkOutput("ovfE2Wrap", {31'd0, ovfW}, 32'd1);
        checkOutput("ovfE2WrapScore", {16'd0, scoreW}, 32'h0000);
        checkOutput("ovfE2Sat", {31'd0, ovfS}, 32'd1);
        checkOutput("ovfE2SatScore", {16'd0, scoreS}, 32'h9999);
        add_cube = 1'b0;
        step(1);
        checkOutput("ovfE3Wrap", {31'd0, ovfW}, 32'd0);
        checkOutput("ovfE3Sat", {31'd0, ovfS}, 32'd0);
        step(1);
        modelAdd();
        applyStimulus(2, 2, 2);
        checkOutput("postWrapScore", {16'd0, scoreW}, {16'd0, toBcd(modelW)});
        checkOutput("postSatScore", {16'd0, scoreS}, 32'h9999);
        step(2);
        checkOutput("ovfCountWrap", ovfSeenW, ovfExpW);
        checkOutput("ovfCountSat", ovfSeenS, ovfExpS);
        checkOutput("ovfCountSatAbs", ovfSeenS, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
